// File: rtl/led_mode_sequencer_if.sv
// Button, auto-enable and selector signals of the LED mode sequencer.
// The master drives the raw buttons and auto_en, the slave drives selector and mode_changed.
interface led_mode_sequencer_if;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic [2:0] selector;
    logic       mode_changed;

    modport master (
        output btn_next, btn_prev, auto_en,
        input  selector, mode_changed
    );

    modport slave (
        input  btn_next, btn_prev, auto_en,
        output selector, mode_changed
    );
endinterface

// File: rtl/led_mode_sequencer.sv
// LED pattern selector stepped by two debounced buttons; define LED_SEQ_AUTO_EN to add
// an auto-advance timer gated by auto_en (absent otherwise).
module led_mode_sequencer #(
    parameter int unsigned NUM_MODES       = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned AUTO_PERIOD     = 50000000
) (
    input  logic                clk,
    input  logic                rst,
    led_mode_sequencer_if.slave bus
);
    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      SEL_MAX = 3'(NUM_MODES - 1);

    // Bit 0 carries btn_next, bit 1 carries btn_prev through the whole pipeline.
    logic [1:0]      raw;
    logic [1:0]      sync1_q, sync2_q, deb_q, deb_prev_q, press_q;
    logic [DB_W-1:0] cnt_q [2];
    logic [2:0]      selector_q, selector_d;
    logic            mode_changed_q, mode_changed_d;
    logic            step_next, step_prev;
    logic            auto_tick;

    assign raw = {bus.btn_prev, bus.btn_next};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef LED_SEQ_AUTO_EN
    localparam int unsigned     AT_W    = $clog2(AUTO_PERIOD);
    localparam logic [AT_W-1:0] AT_LAST = AT_W'(AUTO_PERIOD - 1);

    logic [AT_W-1:0] timer_q, timer_d;

    assign auto_tick = bus.auto_en && (timer_q == AT_LAST);

    // Any button event restarts the period, so a coinciding tick is simply lost.
    always_comb begin
        timer_d = timer_q + 1'b1;
        if (!bus.auto_en || (press_q != '0) || auto_tick) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic unused_auto;
    assign unused_auto = bus.auto_en ^ (AUTO_PERIOD == 0);
    assign auto_tick   = 1'b0;
`endif

    always_comb begin
        step_next = 1'b0;
        step_prev = 1'b0;
        if (press_q == 2'b01) begin
            step_next = 1'b1;
        end else if (press_q == 2'b10) begin
            step_prev = 1'b1;
        end else if (press_q == 2'b00) begin
            step_next = auto_tick;
        end

        selector_d = selector_q;
        if (step_next) begin
            selector_d = (selector_q >= SEL_MAX) ? '0 : selector_q + 3'd1;
        end else if (step_prev) begin
            selector_d = ((selector_q == '0) || (selector_q > SEL_MAX)) ? SEL_MAX
                                                                        : selector_q - 3'd1;
        end
        mode_changed_d = (selector_d != selector_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            selector_q     <= '0;
            mode_changed_q <= 1'b0;
        end else begin
            selector_q     <= selector_d;
            mode_changed_q <= mode_changed_d;
        end
    end

    assign bus.selector     = selector_q;
    assign bus.mode_changed = mode_changed_q;
endmodule

// File: tb/tb_led_mode_sequencer.sv
// Randomized bench for led_mode_sequencer against a sample-window reference model.
// Auto-advance scenarios are exercised only when LED_SEQ_AUTO_EN is defined.
module tb_led_mode_sequencer;
    localparam int NM = 6;
    localparam int D  = 4;
    localparam int AP = 8;

    logic clk;
    logic rst;

    led_mode_sequencer_if seq_if ();

    led_mode_sequencer #(
        .NUM_MODES      (NM),
        .DEBOUNCE_CYCLES(D),
        .AUTO_PERIOD    (AP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(seq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: raw sample history per button, debounced level, events in flight.
    logic       hist [0:1][0:D];
    logic       deb_m [0:1];
    logic [1:0] sched0, sched1;
    int         sel_m;
    logic       mc_m;
    int         run_m;

    logic       cur_rst;
    logic [1:0] cur_in;
    logic       cur_auto;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // A press is accepted once D consecutive synchronized samples (raw delayed two edges)
    // disagree with the debounced level; the selector moves two edges after acceptance.
    task automatic model_edge();
        logic [1:0] fresh;
        logic       bn, bp, tick, agree;
        int         prev;
        if (cur_rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int j = 0; j <= D; j++) hist[b][j] = 1'b0;
                deb_m[b] = 1'b0;
            end
            sched0 = '0;
            sched1 = '0;
            sel_m  = 0;
            mc_m   = 1'b0;
            run_m  = 0;
            return;
        end
        bn     = sched0[0];
        bp     = sched0[1];
        sched0 = sched1;
        fresh  = '0;
        for (int b = 0; b < 2; b++) begin
            agree = 1'b1;
            for (int j = 0; j < D; j++) if (hist[b][j] == deb_m[b]) agree = 1'b0;
            if (agree) begin
                deb_m[b] = !deb_m[b];
                if (deb_m[b]) fresh[b] = 1'b1;
            end
            for (int j = 0; j < D; j++) hist[b][j] = hist[b][j+1];
            hist[b][D] = cur_in[b];
        end
        sched1 = fresh;
        tick   = 1'b0;
`ifdef LED_SEQ_AUTO_EN
        if (!cur_auto || bn || bp) begin
            run_m = 0;
        end else begin
            run_m++;
            if (run_m == AP) begin
                tick  = 1'b1;
                run_m = 0;
            end
        end
`endif
        prev = sel_m;
        if (bn && !bp)              sel_m = (sel_m + 1) % NM;
        else if (bp && !bn)         sel_m = (sel_m + NM - 1) % NM;
        else if (!bn && !bp && tick) sel_m = (sel_m + 1) % NM;
        mc_m = (sel_m != prev);
    endtask

    task automatic cycle(input logic r, input logic n, input logic p, input logic a);
        cur_rst          = r;
        cur_in           = {p, n};
        cur_auto         = a;
        rst              = r;
        seq_if.btn_next  = n;
        seq_if.btn_prev  = p;
        seq_if.auto_en   = a;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("selector", {29'd0, seq_if.selector}, sel_m);
        check_eq("mode_changed", {31'd0, seq_if.mode_changed}, {31'd0, mc_m});
    endtask

    task automatic clean_press(input int which, input logic a);
        repeat (D + 4) cycle(1'b0, which == 0, which == 1, a);
        repeat (D + 3) cycle(1'b0, 1'b0, 1'b0, a);
    endtask

    int   expv;
    int   kind;
    int   len;
    logic a;
    logic rn, rp;

    initial begin
        // Reset and first-press latency
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("rst_sel", {29'd0, seq_if.selector}, 0);
        check_eq("rst_chg", {31'd0, seq_if.mode_changed}, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (D + 2) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("lat_early", {29'd0, seq_if.selector}, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("lat_sel", {29'd0, seq_if.selector}, 1);
        check_eq("lat_pulse", {31'd0, seq_if.mode_changed}, 1);
        repeat (8) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("held", {29'd0, seq_if.selector}, 1);
        repeat (D + 4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("release", {29'd0, seq_if.selector}, 1);

        // Wrap forward and backward
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NM; i++) begin
            clean_press(0, 1'b0);
            check_eq("wrap_next", {29'd0, seq_if.selector}, (i + 1) % NM);
        end
        clean_press(1, 1'b0);
        check_eq("wrap_prev", {29'd0, seq_if.selector}, NM - 1);

        // Bounce only, then bounce settling high
        expv = sel_m;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'(i % 2), 1'b0, 1'b0);
        repeat (D + 4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("bounce_low", {29'd0, seq_if.selector}, expv);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'(i % 2), 1'b0, 1'b0);
        repeat (D + 6) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("bounce_high", {29'd0, seq_if.selector}, (expv + 1) % NM);
        repeat (D + 4) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Both buttons on the same edge cancel
        expv = (expv + 1) % NM;
        repeat (D + 8) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("simul", {29'd0, seq_if.selector}, expv);
        repeat (D + 4) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of debouncing a held button
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("midrst_sel", {29'd0, seq_if.selector}, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (D + 2) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("midrst_early", {29'd0, seq_if.selector}, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("midrst_adv", {29'd0, seq_if.selector}, 1);
        repeat (D + 4) cycle(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef LED_SEQ_AUTO_EN
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= NM + 1; k++) begin
            repeat (AP) cycle(1'b0, 1'b0, 1'b0, 1'b1);
            check_eq("auto", {29'd0, seq_if.selector}, k % NM);
        end
`endif

        // Randomized bursts, reference model checked every cycle
        for (int burst = 0; burst < 200; burst++) begin
            kind = int'($urandom_range(0, 6));
            a    = 1'($urandom_range(0, 1));
            case (kind)
                0, 1: begin
                    len = int'($urandom_range(1, D + 8));
                    repeat (len) cycle(1'b0, kind == 0, kind == 1, a);
                    len = int'($urandom_range(0, D + 4));
                    repeat (len) cycle(1'b0, 1'b0, 1'b0, a);
                end
                2: repeat (20) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
                3: begin
                    len = int'($urandom_range(1, D + 8));
                    repeat (len) cycle(1'b0, 1'b1, 1'b1, a);
                end
                4: begin
                    len = int'($urandom_range(1, 2));
                    repeat (len) cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
                end
                5: begin
                    len = int'($urandom_range(1, 20));
                    repeat (len) cycle(1'b0, 1'b0, 1'b0, a);
                end
                default: begin
                    rn = 1'b0;
                    rp = 1'b0;
                    repeat (30) begin
                        if ($urandom_range(0, 5) == 0) rn = !rn;
                        if ($urandom_range(0, 5) == 0) rp = !rp;
                        cycle(1'b0, rn, rp, a);
                    end
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/led_mode_sequencer.md
LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 Parameter NUM_MODES, default 6: number of LED patterns; selector range 0..NUM_MODES-1 (2..8 legal).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples needed to accept a button level change (>=2).
REQ-003 Parameter AUTO_PERIOD, default 50000000: clock cycles between automatic advances (>=2; used only with LED_SEQ_AUTO_EN).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 btn_next  input  1  raw asynchronous button, active-high, advances mode.
REQ-007 btn_prev  input  1  raw asynchronous button, active-high, steps mode back.
REQ-008 auto_en  input  1  level, enables automatic cycling (ignored without LED_SEQ_AUTO_EN).
REQ-009 selector  output  3  current pattern index; drives the 3-bit select of the LED pattern mux.
REQ-010 mode_changed  output  1  one-cycle pulse, high in the first cycle a new selector value is presented.

Function
REQ-011 Each button SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-012 Each synchronized button SHALL be debounced by its own counter: counter clears whenever the synchronized level equals the debounced level; otherwise it increments; when it reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced level takes the synchronized level and the counter clears.
REQ-013 A press event SHALL be a 0->1 transition of a debounced level; a release SHALL produce no event; a held button SHALL produce exactly one event.
REQ-014 Latency: raw button high from clock edge N (first edge sampling it high) and held SHALL give a new selector value after edge N+DEBOUNCE_CYCLES+3.
REQ-015 Next event: selector = selector+1, wrapping NUM_MODES-1 -> 0.
REQ-016 Prev event: selector = selector-1, wrapping 0 -> NUM_MODES-1.
REQ-017 Next and prev events in the same cycle SHALL cancel: selector unchanged, no mode_changed pulse.
REQ-018 selector SHALL never take a value >= NUM_MODES.
REQ-019 mode_changed SHALL assert for exactly one cycle, coincident with the first cycle the updated selector is visible, and only when the value actually changes.
REQ-020 Arithmetic SHALL be modulo NUM_MODES on 3-bit values; no intermediate overflow reaches selector.

Reset
REQ-021 With rst high at a rising edge: selector=0, mode_changed=0, synchronizer flops=0, debounced levels=0, debounce counters=0, auto timer=0.
REQ-022 A button held across reset deassertion SHALL be treated as a fresh press and produce one event after the full REQ-014 latency.
REQ-023 Reset mid-debounce or mid-auto-period SHALL discard all partial progress; no event is generated from pre-reset activity.

Configuration
REQ-024 Macro LED_SEQ_AUTO_EN defined: a timer counts cycles while auto_en=1; on reaching AUTO_PERIOD-1 it produces an auto-next event (same effect as REQ-015) and clears.
REQ-025 Auto timer SHALL clear when auto_en=0 and on any accepted button event; a button event coinciding with an auto tick SHALL win, the auto tick being dropped.
REQ-026 Macro LED_SEQ_AUTO_EN undefined: no timer logic is present, auto_en is unused, selector changes only on button events.

Verification
REQ-027 Reset, DEBOUNCE_CYCLES=4: rst high 2 cycles -> selector=0, mode_changed=0; btn_next held from edge 10 -> selector=1 after edge 17 with one mode_changed pulse, no further change while held.
REQ-028 Wrap: six clean next presses from 0 -> selector 1,2,3,4,5,0; one prev press at 0 -> selector=5.
REQ-029 Bounce: btn_next toggling every cycle for 20 cycles then low -> selector unchanged, no pulse; toggling then held high -> exactly one advance.
REQ-030 Simultaneous: btn_next and btn_prev asserted on the same edge, held -> selector unchanged, no mode_changed pulse.
REQ-031 Auto (LED_SEQ_AUTO_EN, AUTO_PERIOD=8, auto_en=1): selector advances every 8 cycles 0->1->...->5->0; next press landing on a tick cycle -> single advance, next auto advance 8 cycles later.
REQ-032 Reset mid-operation: rst asserted 2 cycles into a 4-cycle debounce -> no advance, selector=0; button still held -> advance after full latency from reset release.
